// File: rtl/rsm_pkg.sv
// Shared types and constants for the multicycle controller's fetch front end.
package rsm_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    ISSUE = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  localparam logic [2:0] OPC_HALT = 3'b111;

  // Instruction field positions (msb/lsb) within the 16-bit IR
  localparam int OPC_MSB   = 15;
  localparam int OPC_LSB   = 13;
  localparam int ALU_MSB   = 12;
  localparam int ALU_LSB   = 11;
  localparam int RN_MSB    = 10;
  localparam int RN_LSB    = 8;
  localparam int RD_MSB    = 7;
  localparam int RD_LSB    = 5;
  localparam int SHIFT_MSB = 4;
  localparam int SHIFT_LSB = 3;
  localparam int RM_MSB    = 2;
  localparam int RM_LSB    = 0;

  localparam logic [1:0] REG_SEL_RM = 2'b00;
  localparam logic [1:0] REG_SEL_RD = 2'b01;
  localparam logic [1:0] REG_SEL_RN = 2'b10;

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

  function automatic logic [15:0] sext5(input logic [4:0] v);
    return {{11{v[4]}}, v};
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational field extraction from the IR plus register-number mux for the regfile.
module instr_decoder
  import rsm_pkg::*;
(
  input  logic [15:0] ir,
  input  logic [1:0]  reg_sel,
  output logic [2:0]  opcode,
  output logic [1:0]  alu_op,
  output logic [1:0]  shift_op,
  output logic [2:0]  reg_num,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5
);

  assign opcode   = ir[OPC_MSB:OPC_LSB];
  assign alu_op   = ir[ALU_MSB:ALU_LSB];
  assign shift_op = ir[SHIFT_MSB:SHIFT_LSB];
  assign sximm8   = sext8(ir[7:0]);
  assign sximm5   = sext5(ir[4:0]);

  always_comb begin
    reg_num = 3'b000;
    case (reg_sel)
      REG_SEL_RM: reg_num = ir[RM_MSB:RM_LSB];
      REG_SEL_RD: reg_num = ir[RD_MSB:RD_LSB];
      REG_SEL_RN: reg_num = ir[RN_MSB:RN_LSB];
      default:    reg_num = 3'b000;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetches instructions into the IR, issues one start per instruction and
// waits for the controller to return to idle before fetching the next.
module instr_fetch_unit
  import rsm_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_rvalid,
  input  logic              ctrl_waiting,
  input  logic [1:0]        ctrl_reg_sel,
  output logic              start,
  output logic [2:0]        opcode,
  output logic [1:0]        alu_op,
  output logic [1:0]        shift_op,
  output logic [2:0]        reg_num,
  output logic [15:0]       sximm8,
  output logic [15:0]       sximm5,
  output logic [15:0]       ir,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);

  fetch_state_t state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FETCH;
      pc    <= PC_INIT;
      ir    <= 16'h0000;
    end else begin
      case (state)
        FETCH: begin
          if (mem_rvalid) begin
            ir    <= mem_rdata;
            pc    <= pc + ADDR_W'(1);
            state <= ISSUE;
          end
        end
        ISSUE: begin
          // Controller dropping waiting means it accepted the start pulse
          if (!ctrl_waiting)
            state <= (ir[OPC_MSB:OPC_LSB] == OPC_HALT) ? HALT : EXEC;
        end
        EXEC: begin
          if (ctrl_waiting)
            state <= FETCH;
        end
        default: state <= HALT;
      endcase
    end
  end

  // Request lines are held low for the whole reset cycle, whatever the state
  assign mem_req  = rst_n && (state == FETCH);
  assign start    = rst_n && (state == ISSUE);
  assign halted   = (state == HALT);
  assign mem_addr = pc;

  instr_decoder u_decoder (
    .ir       (ir),
    .reg_sel  (ctrl_reg_sel),
    .opcode   (opcode),
    .alu_op   (alu_op),
    .shift_op (shift_op),
    .reg_num  (reg_num),
    .sximm8   (sximm8),
    .sximm5   (sximm5)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit (default instance plus a 4-bit wrap instance).
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rdata = 16'h0000;
  logic        mem_rvalid = 1'b0;
  logic        ctrl_waiting = 1'b1;
  logic [1:0]  ctrl_reg_sel = 2'b00;
  logic        start;
  logic [2:0]  opcode;
  logic [1:0]  alu_op;
  logic [1:0]  shift_op;
  logic [2:0]  reg_num;
  logic [15:0] sximm8;
  logic [15:0] sximm5;
  logic [15:0] ir;
  logic [7:0]  pc;
  logic        halted;

  logic        w_rst_n = 1'b0;
  logic        w_mem_req;
  logic [3:0]  w_mem_addr;
  logic [15:0] w_mem_rdata = 16'h0000;
  logic        w_mem_rvalid = 1'b0;
  logic        w_ctrl_waiting = 1'b1;
  logic        w_start;
  logic [2:0]  w_opcode;
  logic [1:0]  w_alu_op;
  logic [1:0]  w_shift_op;
  logic [2:0]  w_reg_num;
  logic [15:0] w_sximm8;
  logic [15:0] w_sximm5;
  logic [15:0] w_ir;
  logic [3:0]  w_pc;
  logic        w_halted;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(8), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .ctrl_waiting(ctrl_waiting),
    .ctrl_reg_sel(ctrl_reg_sel), .start(start), .opcode(opcode), .alu_op(alu_op),
    .shift_op(shift_op), .reg_num(reg_num), .sximm8(sximm8), .sximm5(sximm5),
    .ir(ir), .pc(pc), .halted(halted)
  );

  instr_fetch_unit #(.ADDR_W(4), .RESET_PC(15)) dut_wrap (
    .clk(clk), .rst_n(w_rst_n), .mem_req(w_mem_req), .mem_addr(w_mem_addr),
    .mem_rdata(w_mem_rdata), .mem_rvalid(w_mem_rvalid), .ctrl_waiting(w_ctrl_waiting),
    .ctrl_reg_sel(2'b00), .start(w_start), .opcode(w_opcode), .alu_op(w_alu_op),
    .shift_op(w_shift_op), .reg_num(w_reg_num), .sximm8(w_sximm8), .sximm5(w_sximm5),
    .ir(w_ir), .pc(w_pc), .halted(w_halted)
  );

  // Outputs are sampled 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_rvalid = 1'b0; ctrl_waiting = 1'b1;
    step(); step();
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
    n_checks++; if (start !== 1'b0) begin n_fail++; $display("FAIL reset_start got %b want 0", start); end
    n_checks++; if (pc !== 8'h00) begin n_fail++; $display("FAIL reset_pc got %h want 00", pc); end
    n_checks++; if (ir !== 16'h0000) begin n_fail++; $display("FAIL reset_ir got %h want 0000", ir); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b want 0", halted); end
    rst_n = 1'b1;
    #1;
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL post_reset_mem_req got %b want 1", mem_req); end
    n_checks++; if (mem_addr !== 8'h00) begin n_fail++; $display("FAIL post_reset_addr got %h want 00", mem_addr); end
  endtask

  task automatic test_basic_fetch();
    mem_rdata = 16'hD105; mem_rvalid = 1'b1;
    step();
    mem_rvalid = 1'b0; mem_rdata = 16'h0000;
    n_checks++; if (ir !== 16'hD105) begin n_fail++; $display("FAIL fetch_ir got %h want d105", ir); end
    n_checks++; if (pc !== 8'h01) begin n_fail++; $display("FAIL fetch_pc got %h want 01", pc); end
    n_checks++; if (start !== 1'b1) begin n_fail++; $display("FAIL fetch_start got %b want 1", start); end
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL issue_mem_req got %b want 0", mem_req); end
    n_checks++; if (opcode !== 3'b110) begin n_fail++; $display("FAIL fetch_opcode got %b want 110", opcode); end
    n_checks++; if (alu_op !== 2'b10) begin n_fail++; $display("FAIL fetch_alu_op got %b want 10", alu_op); end
    n_checks++; if (sximm8 !== 16'h0005) begin n_fail++; $display("FAIL fetch_sximm8 got %h want 0005", sximm8); end
    step();
    n_checks++; if (start !== 1'b1) begin n_fail++; $display("FAIL issue_hold_start got %b want 1", start); end
    ctrl_waiting = 1'b0;
    step();
    n_checks++; if (start !== 1'b0) begin n_fail++; $display("FAIL exec_start got %b want 0", start); end
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL exec_mem_req got %b want 0", mem_req); end
    ctrl_waiting = 1'b1;
    step();
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL refetch_mem_req got %b want 1", mem_req); end
    n_checks++; if (mem_addr !== 8'h01) begin n_fail++; $display("FAIL refetch_addr got %h want 01", mem_addr); end
  endtask

  task automatic test_latency();
    mem_rdata = 16'h1234; mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL lat_mem_req[%0d] got %b want 1", i, mem_req); end
      n_checks++; if (mem_addr !== 8'h01) begin n_fail++; $display("FAIL lat_addr[%0d] got %h want 01", i, mem_addr); end
      n_checks++; if (ir !== 16'hD105) begin n_fail++; $display("FAIL lat_ir[%0d] got %h want d105", i, ir); end
    end
    mem_rdata = 16'hA2E8; mem_rvalid = 1'b1;
    step();
    mem_rvalid = 1'b0;
    n_checks++; if (ir !== 16'hA2E8) begin n_fail++; $display("FAIL lat_ir_load got %h want a2e8", ir); end
    n_checks++; if (pc !== 8'h02) begin n_fail++; $display("FAIL lat_pc got %h want 02", pc); end
  endtask

  task automatic test_decode();
    ctrl_reg_sel = 2'b10; #1;
    n_checks++; if (reg_num !== 3'd2) begin n_fail++; $display("FAIL dec_rn got %0d want 2", reg_num); end
    ctrl_reg_sel = 2'b00; #1;
    n_checks++; if (reg_num !== 3'd0) begin n_fail++; $display("FAIL dec_rm got %0d want 0", reg_num); end
    ctrl_reg_sel = 2'b01; #1;
    n_checks++; if (reg_num !== 3'd7) begin n_fail++; $display("FAIL dec_rd got %0d want 7", reg_num); end
    ctrl_reg_sel = 2'b11; #1;
    n_checks++; if (reg_num !== 3'd0) begin n_fail++; $display("FAIL dec_sel11 got %0d want 0", reg_num); end
    n_checks++; if (sximm5 !== 16'h0008) begin n_fail++; $display("FAIL dec_sximm5 got %h want 0008", sximm5); end
    n_checks++; if (sximm8 !== 16'hFFE8) begin n_fail++; $display("FAIL dec_sximm8 got %h want ffe8", sximm8); end
    n_checks++; if (opcode !== 3'b101) begin n_fail++; $display("FAIL dec_opcode got %b want 101", opcode); end
    n_checks++; if (shift_op !== 2'b01) begin n_fail++; $display("FAIL dec_shift got %b want 01", shift_op); end
  endtask

  task automatic test_handshake();
    int starts;
    starts = 1;
    step();
    if (start === 1'b1) starts++;
    ctrl_waiting = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (start === 1'b1) starts++;
      n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL hs_mem_req[%0d] got %b want 0", i, mem_req); end
    end
    n_checks++; if (starts !== 2) begin n_fail++; $display("FAIL hs_start_cycles got %0d want 2", starts); end
    n_checks++; if (pc !== 8'h02) begin n_fail++; $display("FAIL hs_pc got %h want 02", pc); end
    ctrl_waiting = 1'b1;
    step();
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL hs_refetch got %b want 1", mem_req); end
    n_checks++; if (mem_addr !== 8'h02) begin n_fail++; $display("FAIL hs_addr got %h want 02", mem_addr); end
    mem_rdata = 16'h00F0; mem_rvalid = 1'b1;
    step();
    mem_rvalid = 1'b0;
    n_checks++; if (sximm8 !== 16'hFFF0) begin n_fail++; $display("FAIL neg_sximm8 got %h want fff0", sximm8); end
    n_checks++; if (sximm5 !== 16'hFFF0) begin n_fail++; $display("FAIL neg_sximm5 got %h want fff0", sximm5); end
    n_checks++; if (pc !== 8'h03) begin n_fail++; $display("FAIL neg_pc got %h want 03", pc); end
    ctrl_waiting = 1'b0;
    step();
    ctrl_waiting = 1'b1;
    step();
  endtask

  task automatic test_halt();
    mem_rdata = 16'hE000; mem_rvalid = 1'b1;
    step();
    mem_rvalid = 1'b0;
    n_checks++; if (start !== 1'b1) begin n_fail++; $display("FAIL halt_issue_start got %b want 1", start); end
    n_checks++; if (pc !== 8'h04) begin n_fail++; $display("FAIL halt_pc got %h want 04", pc); end
    ctrl_waiting = 1'b0;
    step();
    ctrl_waiting = 1'b1; mem_rvalid = 1'b1; mem_rdata = 16'h5555;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_flag[%0d] got %b want 1", i, halted); end
      n_checks++; if (mem_req !== 1'b0 || start !== 1'b0) begin n_fail++; $display("FAIL halt_quiet[%0d] got req=%b start=%b want 0/0", i, mem_req, start); end
      n_checks++; if (ir !== 16'hE000) begin n_fail++; $display("FAIL halt_ir[%0d] got %h want e000", i, ir); end
      step();
    end
    mem_rvalid = 1'b0;
  endtask

  task automatic test_reset_abort();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL abort_pre_req got %b want 1", mem_req); end
    rst_n = 1'b0;
    step();
    mem_rdata = 16'hBEEF; mem_rvalid = 1'b1;
    step();
    mem_rvalid = 1'b0;
    n_checks++; if (ir !== 16'h0000) begin n_fail++; $display("FAIL abort_ir got %h want 0000", ir); end
    n_checks++; if (pc !== 8'h00) begin n_fail++; $display("FAIL abort_pc got %h want 00", pc); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL abort_halted got %b want 0", halted); end
    rst_n = 1'b1;
    step();
    n_checks++; if (ir !== 16'h0000 || mem_req !== 1'b1) begin n_fail++; $display("FAIL abort_after got ir=%h req=%b want 0000/1", ir, mem_req); end
  endtask

  task automatic test_pc_wrap();
    w_rst_n = 1'b0;
    step();
    w_rst_n = 1'b1; #1;
    n_checks++; if (w_mem_addr !== 4'hF) begin n_fail++; $display("FAIL wrap_first_addr got %h want f", w_mem_addr); end
    w_mem_rdata = 16'h0000; w_mem_rvalid = 1'b1;
    step();
    w_mem_rvalid = 1'b0;
    n_checks++; if (w_pc !== 4'h0) begin n_fail++; $display("FAIL wrap_pc got %h want 0", w_pc); end
    w_ctrl_waiting = 1'b0;
    step();
    w_ctrl_waiting = 1'b1;
    step();
    n_checks++; if (w_mem_req !== 1'b1 || w_mem_addr !== 4'h0) begin n_fail++; $display("FAIL wrap_second got req=%b addr=%h want 1/0", w_mem_req, w_mem_addr); end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_latency();
    test_decode();
    test_handshake();
    test_halt();
    test_reset_abort();
    test_pc_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
